disp_scheduler: RTL and testbench

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_disp_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
// disp_scheduler -- shares one 8-digit seven-segment display among four
// requesters, with an optional full-screen banner that overrides them all.
//
// Every ownership change passes through BLANK, an all-off gap of
// BLANK_CYCLES cycles. An owner holds the display for at least HOLD_CYCLES
// cycles before a higher-priority requester can take it. A lower-priority
// requester can never take the display from the current owner.
//
// Configuration macro: DISP_SCHEDULER_BANNER_EN
//   defined   : the BANNER state, the pending-banner flag and the banner
//               timer are built.
//   undefined : banner_req, an_banner and seg_banner are ignored, and
//               banner_active is tied low.
//
// Parameters
//   HOLD_CYCLES   minimum ownership time before a higher priority may preempt
//   BLANK_CYCLES  all-off cycles inserted at every ownership change
//   BANNER_CYCLES length of one banner showing
//   Any parameter value below 1 is treated as 1.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   req[3:0]        display requests; bit 0 has the highest priority
//   an_in0..3       per-requester anode patterns (active-low, 8 bits)
//   seg_in0..3      per-requester segment patterns (active-low, 7 bits)
//   banner_req      single-cycle pulse that requests the banner
//   an_banner       banner anode pattern
//   seg_banner      banner segment pattern
//   AN              registered anode drive
//   led             registered segment drive
//   grant           one-hot current owner, or zero when there is no owner
//   banner_active   high while the banner is displayed
//
// Timing: all outputs are registered from the current state. grant, AN and
// led therefore change together, one cycle after a state transition. While
// a requester owns the display, AN and led follow that requester's inputs
// with one cycle of latency.
module disp_scheduler #(
  parameter int HOLD_CYCLES   = 100000000,
  parameter int BLANK_CYCLES  = 16,
  parameter int BANNER_CYCLES = 200000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] an_in0,
  input  logic [7:0] an_in1,
  input  logic [7:0] an_in2,
  input  logic [7:0] an_in3,
  input  logic [6:0] seg_in0,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in3,
  input  logic       banner_req,
  input  logic [7:0] an_banner,
  input  logic [6:0] seg_banner,
  output logic [7:0] AN,
  output logic [6:0] led,
  output logic [3:0] grant,
  output logic       banner_active
);

  localparam int HOLD_N   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  localparam int BLANK_N  = (BLANK_CYCLES  < 1) ? 1 : BLANK_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_N + 1);
  localparam int BLANK_W  = $clog2(BLANK_N + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_N - 1);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_N - 1);

`ifdef DISP_SCHEDULER_BANNER_EN
  localparam int BANNER_N = (BANNER_CYCLES < 1) ? 1 : BANNER_CYCLES;
  localparam int BANNER_W = $clog2(BANNER_N + 1);
  localparam logic [BANNER_W-1:0] BANNER_MAX = BANNER_W'(BANNER_N - 1);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    OWN    = 2'd1,
    BANNER = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    OWN   = 2'd1
  } state_t;
`endif

  state_t             state_r, state_nxt_s;
  logic [3:0]         owner_r, owner_nxt_s;
  logic [BLANK_W-1:0] blank_cnt_r, blank_cnt_nxt_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
  logic               take_banner_s;
  logic [7:0]         an_sel_s;
  logic [6:0]         seg_sel_s;

`ifdef DISP_SCHEDULER_BANNER_EN
  logic                banner_pending_r, banner_pending_nxt_s;
  logic [BANNER_W-1:0] banner_cnt_r, banner_cnt_nxt_s;

  // A pulse arriving this cycle counts immediately, so the owner is dropped
  // at the next edge rather than one cycle later.
  assign take_banner_s = banner_pending_r | banner_req;
`else
  logic unused_banner_s;

  assign take_banner_s   = 1'b0;
  assign unused_banner_s = ^{banner_req, an_banner, seg_banner};
`endif

  // Highest-priority (lowest-index) set bit of a request vector, as one-hot.
  function automatic logic [3:0] pick_first(input logic [3:0] r);
    logic [3:0] g;
    casez (r)
      4'b???1: g = 4'b0001;
      4'b??10: g = 4'b0010;
      4'b?100: g = 4'b0100;
      4'b1000: g = 4'b1000;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  // Select the current owner's display patterns.
  always_comb begin
    an_sel_s  = 8'hFF;
    seg_sel_s = 7'h7F;
    case (owner_r)
      4'b0001: begin an_sel_s = an_in0; seg_sel_s = seg_in0; end
      4'b0010: begin an_sel_s = an_in1; seg_sel_s = seg_in1; end
      4'b0100: begin an_sel_s = an_in2; seg_sel_s = seg_in2; end
      4'b1000: begin an_sel_s = an_in3; seg_sel_s = seg_in3; end
      default: begin an_sel_s = 8'hFF;  seg_sel_s = 7'h7F;   end
    endcase
  end

  // Next-state, ownership and counter logic.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    blank_cnt_nxt_s = blank_cnt_r;
    hold_cnt_nxt_s  = hold_cnt_r;
`ifdef DISP_SCHEDULER_BANNER_EN
    banner_cnt_nxt_s     = banner_cnt_r;
    banner_pending_nxt_s = take_banner_s;
`endif
    case (state_r)
      BLANK: begin
        if (blank_cnt_r == BLANK_MAX) begin
          if (take_banner_s) begin
            owner_nxt_s = 4'b0000;
`ifdef DISP_SCHEDULER_BANNER_EN
            state_nxt_s          = BANNER;
            banner_cnt_nxt_s     = {BANNER_W{1'b0}};
            banner_pending_nxt_s = 1'b0;
`endif
          end else if (req != 4'b0000) begin
            state_nxt_s    = OWN;
            owner_nxt_s    = pick_first(req);
            hold_cnt_nxt_s = {HOLD_W{1'b0}};
          end else begin
            owner_nxt_s = 4'b0000;
          end
        end else begin
          blank_cnt_nxt_s = blank_cnt_r + BLANK_W'(1);
        end
      end
      OWN: begin
        // owner_r - 1 masks every bit below the one-hot owner, which are
        // exactly the higher-priority requesters.
        if (take_banner_s ||
            ((req & owner_r) == 4'b0000) ||
            ((hold_cnt_r == HOLD_MAX) && ((req & (owner_r - 4'd1)) != 4'b0000))) begin
          state_nxt_s     = BLANK;
          blank_cnt_nxt_s = {BLANK_W{1'b0}};
          owner_nxt_s     = 4'b0000;
        end else if (hold_cnt_r != HOLD_MAX) begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_nxt_s = hold_cnt_r;
        end
      end
`ifdef DISP_SCHEDULER_BANNER_EN
      BANNER: begin
        banner_pending_nxt_s = 1'b0;
        if (banner_req) begin
          // A new pulse restarts the banner and wins over the terminal count.
          banner_cnt_nxt_s = {BANNER_W{1'b0}};
        end else if (banner_cnt_r == BANNER_MAX) begin
          state_nxt_s      = BLANK;
          blank_cnt_nxt_s  = {BLANK_W{1'b0}};
          banner_cnt_nxt_s = {BANNER_W{1'b0}};
        end else begin
          banner_cnt_nxt_s = banner_cnt_r + BANNER_W'(1);
        end
      end
`endif
      default: begin
        state_nxt_s     = BLANK;
        blank_cnt_nxt_s = {BLANK_W{1'b0}};
        owner_nxt_s     = 4'b0000;
      end
    endcase
  end

  // State, ownership and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BLANK;
      owner_r     <= 4'b0000;
      blank_cnt_r <= {BLANK_W{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
`ifdef DISP_SCHEDULER_BANNER_EN
      banner_cnt_r     <= {BANNER_W{1'b0}};
      banner_pending_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      blank_cnt_r <= blank_cnt_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
`ifdef DISP_SCHEDULER_BANNER_EN
      banner_cnt_r     <= banner_cnt_nxt_s;
      banner_pending_r <= banner_pending_nxt_s;
`endif
    end
  end

  // Registered display drive, grant and banner flag, taken from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      AN            <= 8'hFF;
      led           <= 7'h7F;
      grant         <= 4'b0000;
      banner_active <= 1'b0;
    end else begin
      case (state_r)
        OWN: begin
          AN            <= an_sel_s;
          led           <= seg_sel_s;
          grant         <= owner_r;
          banner_active <= 1'b0;
        end
`ifdef DISP_SCHEDULER_BANNER_EN
        BANNER: begin
          AN            <= an_banner;
          led           <= seg_banner;
          grant         <= 4'b0000;
          banner_active <= 1'b1;
        end
`endif
        default: begin
          AN            <= 8'hFF;
          led           <= 7'h7F;
          grant         <= 4'b0000;
          banner_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler with HOLD_CYCLES=8, BLANK_CYCLES=2
// and BANNER_CYCLES=6. Directed request and banner sequences come first,
// followed by randomized traffic. A timer-based reference model predicts
// AN, led, grant and banner_active for every cycle.
module tb_disp_scheduler;

  localparam int H  = 8;
  localparam int B  = 2;
  localparam int BN = 6;
`ifdef DISP_SCHEDULER_BANNER_EN
  localparam bit BANNER_ON = 1'b1;
`else
  localparam bit BANNER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] an_in0, an_in1, an_in2, an_in3, an_banner;
  logic [6:0] seg_in0, seg_in1, seg_in2, seg_in3, seg_banner;
  logic       banner_req;
  logic [7:0] AN;
  logic [6:0] led;
  logic [3:0] grant;
  logic       banner_active;

  int total = 0;
  int bad   = 0;

  // Reference model: who is showing and for how long
  int  m_owner   = -1;    // -1: nobody owns the display (blank gap)
  bit  m_banner  = 1'b0;  // banner currently showing
  int  m_elapsed = 0;     // cycles spent in the current phase
  bit  m_pend    = 1'b0;  // banner requested but not yet started
  logic [7:0] e_an;
  logic [6:0] e_led;
  logic [3:0] e_grant;
  logic       e_active;

  always #5 clk = ~clk;

  disp_scheduler #(
    .HOLD_CYCLES  (H),
    .BLANK_CYCLES (B),
    .BANNER_CYCLES(BN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .an_in0       (an_in0),
    .an_in1       (an_in1),
    .an_in2       (an_in2),
    .an_in3       (an_in3),
    .seg_in0      (seg_in0),
    .seg_in1      (seg_in1),
    .seg_in2      (seg_in2),
    .seg_in3      (seg_in3),
    .banner_req   (banner_req),
    .an_banner    (an_banner),
    .seg_banner   (seg_banner),
    .AN           (AN),
    .led          (led),
    .grant        (grant),
    .banner_active(banner_active)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] an_of(input int i);
    case (i)
      0: return an_in0;
      1: return an_in1;
      2: return an_in2;
      default: return an_in3;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int i);
    case (i)
      0: return seg_in0;
      1: return seg_in1;
      2: return seg_in2;
      default: return seg_in3;
    endcase
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge
  task automatic model_step();
    bit   pend_now;
    bit   drop;
    int   first;
    logic [3:0] one;
    one = 4'b0001;
    if (reset) begin
      e_an = 8'hFF; e_led = 7'h7F; e_grant = 4'b0000; e_active = 1'b0;
      m_owner = -1; m_banner = 1'b0; m_elapsed = 0; m_pend = 1'b0;
    end else begin
      // The outputs show what the display was doing before this edge
      if (m_banner) begin
        e_an = an_banner; e_led = seg_banner; e_grant = 4'b0000; e_active = 1'b1;
      end else if (m_owner >= 0) begin
        e_an = an_of(m_owner); e_led = seg_of(m_owner);
        e_grant = one << m_owner; e_active = 1'b0;
      end else begin
        e_an = 8'hFF; e_led = 7'h7F; e_grant = 4'b0000; e_active = 1'b0;
      end
      pend_now = BANNER_ON && (m_pend || banner_req);
      if (m_banner) begin
        m_pend = 1'b0;
        if (banner_req) m_elapsed = 0;
        else if (m_elapsed == BN - 1) begin m_banner = 1'b0; m_elapsed = 0; end
        else m_elapsed++;
      end else if (m_owner < 0) begin
        if (m_elapsed >= B - 1) begin
          first = -1;
          for (int i = 3; i >= 0; i--) if (req[i]) first = i;
          if (pend_now) begin
            m_banner = 1'b1; m_elapsed = 0; m_pend = 1'b0;
          end else if (first >= 0) begin
            m_owner = first; m_elapsed = 0; m_pend = 1'b0;
          end else begin
            m_pend = 1'b0;
          end
        end else begin
          m_elapsed++;
          m_pend = pend_now;
        end
      end else begin
        drop = pend_now || !req[m_owner];
        if (m_elapsed >= H - 1)
          for (int i = 0; i < m_owner; i++) if (req[i]) drop = 1'b1;
        m_pend = pend_now;
        if (drop) begin m_owner = -1; m_elapsed = 0; end
        else if (m_elapsed < H - 1) m_elapsed++;
      end
    end
  endtask

  task automatic tick();
    an_in0 = 8'($urandom); an_in1 = 8'($urandom); an_in2 = 8'($urandom); an_in3 = 8'($urandom);
    seg_in0 = 7'($urandom); seg_in1 = 7'($urandom); seg_in2 = 7'($urandom); seg_in3 = 7'($urandom);
    an_banner = 8'($urandom); seg_banner = 7'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("AN", 32'(AN), 32'(e_an));
    check_val("led", 32'(led), 32'(e_led));
    check_val("grant", 32'(grant), 32'(e_grant));
    check_val("banner_active", 32'(banner_active), 32'(e_active));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_banner();
    banner_req = 1'b1;
    tick();
    banner_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0000; banner_req = 1'b0;
    cycles(2);
    reset = 1'b0;
    // Single requester, then a higher priority arriving mid-hold
    req = 4'b0100; cycles(6);
    req = 4'b0101; cycles(20);
    // A lower priority must never preempt; dropping the owner hands over
    req = 4'b1001; cycles(50);
    req = 4'b1000; cycles(10);
    // Banner from OWN, then restarts landing at each point of a banner
    pulse_banner(); cycles(15);
    for (int k = 2; k < 10; k++) begin
      pulse_banner(); cycles(k);
      pulse_banner(); cycles(20);
    end
    // Reset in the middle of a banner leaves nothing pending
    pulse_banner(); cycles(5);
    reset = 1'b1; cycles(1);
    reset = 1'b0; cycles(15);
    // Reset competing with banner_req and requests in the same cycle
    reset = 1'b1; banner_req = 1'b1; req = 4'b1111; cycles(1);
    reset = 1'b0; banner_req = 1'b0; cycles(12);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11, 0) == 0) req[$urandom_range(3, 0)] = ~req[$urandom_range(3, 0)];
      if ($urandom_range(9, 0) == 0) req = 4'($urandom);
      banner_req = ($urandom_range(39, 0) == 0);
      reset      = ($urandom_range(399, 0) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
